// File: rtl/mem_access_pkg.sv
// Shared types and constants for the load/store sequencer.
//   state_t      : sequencer states
//   F3_*         : Funct3 width/extension encodings for loads and stores
//   is_legal_f3  : true when Funct3 names a supported load (load=1) or store
package mem_access_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPTURE,
    WRITE,
    DONE
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic is_legal_f3(input logic load, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = load;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_lane_unit.sv
// Combinational little-endian lane logic.
//   word   : word read from memory
//   wd     : store data (low byte/half used for SB/SH)
//   off    : byte offset within the word (addr[1:0])
//   f3     : Funct3 of the access
//   ext    : load result, lane-selected and sign/zero extended
//   merged : word with only the targeted byte(s) replaced by store data
module lane_unit
  import mem_access_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] word,
  input  logic [DATA_W-1:0] wd,
  input  logic [1:0]        off,
  input  logic [2:0]        f3,
  output logic [DATA_W-1:0] ext,
  output logic [DATA_W-1:0] merged
);

  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  always_comb begin
    sel_b = word[7:0];
    case (off)
      2'd0:    sel_b = word[7:0];
      2'd1:    sel_b = word[15:8];
      2'd2:    sel_b = word[23:16];
      default: sel_b = word[31:24];
    endcase
    sel_h = off[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    ext = word;
    case (f3)
      F3_B:    ext = {{(DATA_W-8){sel_b[7]}}, sel_b};
      F3_H:    ext = {{(DATA_W-16){sel_h[15]}}, sel_h};
      F3_BU:   ext = {{(DATA_W-8){1'b0}}, sel_b};
      F3_HU:   ext = {{(DATA_W-16){1'b0}}, sel_h};
      default: ext = word;
    endcase
  end

  always_comb begin
    merged = word;
    case (f3)
      F3_B: begin
        case (off)
          2'd0:    merged[7:0]   = wd[7:0];
          2'd1:    merged[15:8]  = wd[7:0];
          2'd2:    merged[23:16] = wd[7:0];
          default: merged[31:24] = wd[7:0];
        endcase
      end
      F3_H: begin
        if (off[1]) merged[31:16] = wd[15:0];
        else        merged[15:0]  = wd[15:0];
      end
      F3_W:    merged = wd;
      default: merged = word;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between EX/MEM and a word-wide data memory.
// Sub-word stores are done as read-modify-write since memory writes whole words.
//   clk, reset          : clock, synchronous active-high reset
//   req_valid, MemRead, MemWrite, Funct3, addr, wd : request from EX/MEM
//   ready, busy, done, err, load_data              : status/result to pipeline
//   mem_re, mem_addr, mem_we, mem_wdata, mem_rdata : data memory port
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            Funct3,
  input  logic [DM_ADDRESS-1:0] addr,
  input  logic [DATA_W-1:0]     wd,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DATA_W-1:0]     load_data,
  output logic                  mem_re,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  state_t state, state_n;

  logic [DM_ADDRESS-1:0] addr_q;
  logic [2:0]            f3_q;
  logic                  load_q;
  logic [DATA_W-1:0]     wdata_q;
  logic                  err_q;
  logic [DATA_W-1:0]     load_data_q;

  logic                  accept;
  logic                  misaligned;
  logic                  bad;
  logic [DATA_W-1:0]     ext;
  logic [DATA_W-1:0]     merged;

  // A request with both strobes high is a load.
  assign accept     = (state == IDLE) && req_valid && (MemRead || MemWrite);
  assign misaligned = ((Funct3[1:0] == 2'b01) && addr[0]) ||
                      ((Funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
  assign bad        = !is_legal_f3(MemRead, Funct3) || misaligned;

  // wdata_q doubles as store-data capture and merged-word register,
  // so the merge reads store data from it before overwriting it in CAPTURE.
  lane_unit #(
    .DATA_W (DATA_W)
  ) u_lane (
    .word   (mem_rdata),
    .wd     (wdata_q),
    .off    (addr_q[1:0]),
    .f3     (f3_q),
    .ext    (ext),
    .merged (merged)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (bad)                                state_n = DONE;
          else if (!MemRead && (Funct3 == F3_W))  state_n = WRITE;
          else                                    state_n = READ;
        end
      end
      READ:    state_n = CAPTURE;
      CAPTURE: state_n = load_q ? DONE : WRITE;
      WRITE:   state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    ready     = (state == IDLE);
    busy      = (state != IDLE);
    done      = (state == DONE);
    mem_re    = (state == READ);
    mem_we    = (state == WRITE);
    mem_addr  = '0;
    mem_wdata = '0;
    if (state != IDLE) mem_addr = {addr_q[DM_ADDRESS-1:2], 2'b00};
    if (state == WRITE) mem_wdata = wdata_q;
    err       = err_q;
    load_data = load_data_q;
  end

  // err is loaded at acceptance; for a bad request that edge is also the
  // transition into DONE, and a good request clears it until completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q      <= '0;
      f3_q        <= '0;
      load_q      <= 1'b0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      load_data_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= addr;
        f3_q    <= Funct3;
        load_q  <= MemRead;
        wdata_q <= wd;
        err_q   <= bad;
      end
      if (state == CAPTURE) begin
        if (load_q) load_data_q <= ext;
        else        wdata_q     <= merged;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  localparam int AW = 9;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          MemRead;
  logic          MemWrite;
  logic [2:0]    Funct3;
  logic [AW-1:0] addr;
  logic [DW-1:0] wd;
  logic          ready;
  logic          busy;
  logic          done;
  logic          err;
  logic [DW-1:0] load_data;
  logic          mem_re;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  // Word-wide memory model: registered read, whole-word write.
  logic [DW-1:0] mem [0:127];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[AW-1:2]] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr[AW-1:2]];
  end

  mem_access_ctrl #(
    .DM_ADDRESS (AW),
    .DATA_W     (DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Funct3    (Funct3),
    .addr      (addr),
    .wd        (wd),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .load_data (load_data),
    .mem_re    (mem_re),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Per-request trace: bit k of each mask = value sampled in cycle T+k.
  logic [15:0]   tr_re, tr_we, tr_done, tr_busy;
  logic [DW-1:0] tr_wdata;
  logic [AW-1:0] tr_waddr;
  logic [AW-1:0] tr_raddr;
  logic          tr_err;
  logic [DW-1:0] tr_ld;

  task automatic run_req(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [AW-1:0] a, input logic [DW-1:0] d, input int ncyc);
    tr_re = '0; tr_we = '0; tr_done = '0; tr_busy = '0;
    tr_wdata = '0; tr_waddr = '0; tr_raddr = '0; tr_err = 1'bx; tr_ld = 'x;
    @(negedge clk);
    req_valid = 1'b1; MemRead = rd; MemWrite = wr; Funct3 = f3; addr = a; wd = d;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      tr_re[k]   = mem_re;
      tr_we[k]   = mem_we;
      tr_done[k] = done;
      tr_busy[k] = busy;
      if (mem_we) begin tr_wdata = mem_wdata; tr_waddr = mem_addr; end
      if (mem_re) tr_raddr = mem_addr;
      if (done) begin
        tr_err = err; tr_ld = load_data;
        req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
      end
    end
    req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if ({done, err, mem_re, mem_we} !== 4'b0000) begin errors++; $display("FAIL rst_strobes: got %b expected 0000", {done, err, mem_re, mem_we}); end
    checks++; if (load_data !== 32'h0) begin errors++; $display("FAIL rst_load_data: got %h expected 00000000", load_data); end
    checks++; if ({mem_addr, mem_wdata} !== '0) begin errors++; $display("FAIL rst_mem_port: got %h/%h expected 0/0", mem_addr, mem_wdata); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %b expected 1", ready); end
  endtask

  task automatic test_byte_loads;
    run_req(1'b1, 1'b0, 3'b000, 9'h005, 32'h0, 6);
    checks++; if (tr_done !== 16'h0008) begin errors++; $display("FAIL lb_done_timing: got %h expected 0008", tr_done); end
    checks++; if (tr_re !== 16'h0002) begin errors++; $display("FAIL lb_re_timing: got %h expected 0002", tr_re); end
    checks++; if (tr_busy !== 16'h000E) begin errors++; $display("FAIL lb_busy: got %h expected 000e", tr_busy); end
    checks++; if (tr_we !== 16'h0000) begin errors++; $display("FAIL lb_no_we: got %h expected 0000", tr_we); end
    checks++; if (tr_raddr !== 9'h004) begin errors++; $display("FAIL lb_raddr: got %h expected 004", tr_raddr); end
    checks++; if (tr_ld !== 32'h0000007F) begin errors++; $display("FAIL lb_005: got %h expected 0000007f", tr_ld); end
    checks++; if (tr_err !== 1'b0) begin errors++; $display("FAIL lb_err: got %b expected 0", tr_err); end
    run_req(1'b1, 1'b0, 3'b000, 9'h007, 32'h0, 6);
    checks++; if (tr_ld !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_007: got %h expected ffffff80", tr_ld); end
    run_req(1'b1, 1'b0, 3'b100, 9'h007, 32'h0, 6);
    checks++; if (tr_ld !== 32'h00000080) begin errors++; $display("FAIL lbu_007: got %h expected 00000080", tr_ld); end
    run_req(1'b1, 1'b0, 3'b100, 9'h004, 32'h0, 6);
    checks++; if (tr_ld !== 32'h00000001) begin errors++; $display("FAIL lbu_004: got %h expected 00000001", tr_ld); end
  endtask

  task automatic test_half_word_loads;
    run_req(1'b1, 1'b0, 3'b001, 9'h006, 32'h0, 6);
    checks++; if (tr_ld !== 32'hFFFF80FF) begin errors++; $display("FAIL lh_006: got %h expected ffff80ff", tr_ld); end
    run_req(1'b1, 1'b0, 3'b101, 9'h006, 32'h0, 6);
    checks++; if (tr_ld !== 32'h000080FF) begin errors++; $display("FAIL lhu_006: got %h expected 000080ff", tr_ld); end
    run_req(1'b1, 1'b0, 3'b001, 9'h004, 32'h0, 6);
    checks++; if (tr_ld !== 32'h00007F01) begin errors++; $display("FAIL lh_004: got %h expected 00007f01", tr_ld); end
    run_req(1'b1, 1'b0, 3'b010, 9'h004, 32'h0, 6);
    checks++; if (tr_ld !== 32'h80FF7F01) begin errors++; $display("FAIL lw_004: got %h expected 80ff7f01", tr_ld); end
    checks++; if (tr_done !== 16'h0008) begin errors++; $display("FAIL lw_done_timing: got %h expected 0008", tr_done); end
  endtask

  task automatic test_sub_word_store;
    run_req(1'b0, 1'b1, 3'b001, 9'h00A, 32'h1234BEEF, 7);
    checks++; if (tr_re !== 16'h0002) begin errors++; $display("FAIL sh_re_timing: got %h expected 0002", tr_re); end
    checks++; if (tr_we !== 16'h0008) begin errors++; $display("FAIL sh_we_timing: got %h expected 0008", tr_we); end
    checks++; if (tr_done !== 16'h0010) begin errors++; $display("FAIL sh_done_timing: got %h expected 0010", tr_done); end
    checks++; if (tr_busy !== 16'h001E) begin errors++; $display("FAIL sh_busy: got %h expected 001e", tr_busy); end
    checks++; if (tr_wdata !== 32'hBEEF3344) begin errors++; $display("FAIL sh_wdata: got %h expected beef3344", tr_wdata); end
    checks++; if (tr_waddr !== 9'h008) begin errors++; $display("FAIL sh_waddr: got %h expected 008", tr_waddr); end
    checks++; if (tr_err !== 1'b0) begin errors++; $display("FAIL sh_err: got %b expected 0", tr_err); end
    // load_data belongs to the last load (LW at 0x004)
    checks++; if (tr_ld !== 32'h80FF7F01) begin errors++; $display("FAIL sh_ld_held: got %h expected 80ff7f01", tr_ld); end
    run_req(1'b0, 1'b1, 3'b000, 9'h009, 32'hFFFFFFAA, 7);
    checks++; if (tr_wdata !== 32'hBEEFAA44) begin errors++; $display("FAIL sb_wdata: got %h expected beefaa44", tr_wdata); end
    run_req(1'b1, 1'b0, 3'b010, 9'h008, 32'h0, 6);
    checks++; if (tr_ld !== 32'hBEEFAA44) begin errors++; $display("FAIL sb_readback: got %h expected beefaa44", tr_ld); end
  endtask

  task automatic test_word_store;
    run_req(1'b0, 1'b1, 3'b010, 9'h010, 32'hDEADBEEF, 5);
    checks++; if (tr_we !== 16'h0002) begin errors++; $display("FAIL sw_we_timing: got %h expected 0002", tr_we); end
    checks++; if (tr_waddr !== 9'h010) begin errors++; $display("FAIL sw_waddr: got %h expected 010", tr_waddr); end
    checks++; if (tr_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata: got %h expected deadbeef", tr_wdata); end
    checks++; if (tr_re !== 16'h0000) begin errors++; $display("FAIL sw_no_re: got %h expected 0000", tr_re); end
    checks++; if (tr_done !== 16'h0004) begin errors++; $display("FAIL sw_done_timing: got %h expected 0004", tr_done); end
    checks++; if (tr_err !== 1'b0) begin errors++; $display("FAIL sw_err: got %b expected 0", tr_err); end
    checks++; if (mem[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_mem: got %h expected deadbeef", mem[4]); end
  endtask

  task automatic test_errors;
    logic [2:0]    f3s [3];
    logic [AW-1:0] as  [3];
    logic          rds [3];
    f3s[0] = 3'b010; as[0] = 9'h006; rds[0] = 1'b1;
    f3s[1] = 3'b001; as[1] = 9'h003; rds[1] = 1'b0;
    f3s[2] = 3'b011; as[2] = 9'h004; rds[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_req(rds[i], !rds[i], f3s[i], as[i], 32'h0, 4);
      checks++; if (tr_done !== 16'h0002) begin errors++; $display("FAIL err%0d_done_timing: got %h expected 0002", i, tr_done); end
      checks++; if (tr_err !== 1'b1) begin errors++; $display("FAIL err%0d_err: got %b expected 1", i, tr_err); end
      checks++; if ({tr_re, tr_we} !== 32'h0) begin errors++; $display("FAIL err%0d_strobes: got %h expected 0", i, {tr_re, tr_we}); end
      checks++; if (tr_ld !== 32'hBEEFAA44) begin errors++; $display("FAIL err%0d_ld_held: got %h expected beefaa44", i, tr_ld); end
    end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky_idle: got %b expected 1", err); end
    run_req(1'b0, 1'b1, 3'b011, 9'h004, 32'h0, 4);
    checks++; if (tr_err !== 1'b1) begin errors++; $display("FAIL store_f3_011: got %b expected 1", tr_err); end
    run_req(1'b1, 1'b0, 3'b010, 9'h004, 32'h0, 6);
    checks++; if (tr_err !== 1'b0) begin errors++; $display("FAIL err_cleared: got %b expected 0", tr_err); end
  endtask

  task automatic test_reset_abort;
    logic any_we, any_done;
    any_we = 1'b0; any_done = 1'b0;
    mem[3] = 32'hCAFEF00D;
    @(negedge clk);
    req_valid = 1'b1; MemRead = 1'b0; MemWrite = 1'b1; Funct3 = 3'b000; addr = 9'h00D; wd = 32'h00000055;
    @(negedge clk);
    checks++; if (mem_re !== 1'b1) begin errors++; $display("FAIL abort_read: got %b expected 1", mem_re); end
    @(negedge clk);
    any_we = mem_we;
    reset = 1'b1; req_valid = 1'b0; MemWrite = 1'b0;
    @(negedge clk);
    checks++; if ({ready, busy} !== 2'b10) begin errors++; $display("FAIL abort_ready_busy: got %b expected 10", {ready, busy}); end
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      any_we = any_we | mem_we; any_done = any_done | done;
      @(negedge clk);
    end
    checks++; if (any_we !== 1'b0) begin errors++; $display("FAIL abort_no_we: got %b expected 0", any_we); end
    checks++; if (any_done !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %b expected 0", any_done); end
    checks++; if (mem[3] !== 32'hCAFEF00D) begin errors++; $display("FAIL abort_mem: got %h expected cafef00d", mem[3]); end
  endtask

  task automatic test_decode;
    run_req(1'b0, 1'b0, 3'b010, 9'h004, 32'h0, 4);
    checks++; if ({tr_re, tr_we, tr_done, tr_busy} !== 64'h0) begin errors++; $display("FAIL idle_no_op: got %h expected 0", {tr_re, tr_we, tr_done, tr_busy}); end
    run_req(1'b1, 1'b1, 3'b010, 9'h004, 32'h12345678, 6);
    checks++; if (tr_we !== 16'h0000) begin errors++; $display("FAIL both_no_we: got %h expected 0000", tr_we); end
    checks++; if (tr_re !== 16'h0002) begin errors++; $display("FAIL both_re: got %h expected 0002", tr_re); end
    checks++; if (tr_ld !== 32'h80FF7F01) begin errors++; $display("FAIL both_ld: got %h expected 80ff7f01", tr_ld); end
    checks++; if (mem[1] !== 32'h80FF7F01) begin errors++; $display("FAIL both_mem: got %h expected 80ff7f01", mem[1]); end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = '0;
    mem[1] = 32'h80FF7F01;
    mem[2] = 32'h11223344;
    mem_rdata = '0;
    reset = 1'b1; req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    Funct3 = '0; addr = '0; wd = '0;
    test_reset();
    test_byte_loads();
    test_half_word_loads();
    test_sub_word_store();
    test_word_store();
    test_errors();
    test_reset_abort();
    test_decode();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
